// File: rtl/register_readback_pkg.sv
// -----------------------------------------------------------------------------
// register_readback_pkg
// Shared types and helpers for the register readback engine.
//   rb_state_t  : FSM state encoding (2 bits). PAR is only reachable when the
//                 design is built with REGISTER_READBACK_PARITY_EN defined.
//   cnt_width() : width of the bit counter; it must hold the value WIDTH
//                 without wrapping.
// -----------------------------------------------------------------------------
package register_readback_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } rb_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/register_readback_if.sv
// -----------------------------------------------------------------------------
// register_readback_if
// Request/serial-output bundle of the readback engine.
//   start      : readback request, sampled while ready=1
//   reg_in     : WIDTH-bit parallel register image to snapshot
//   ready      : engine idle, request can be accepted
//   sout       : serial data bit (0 when sout_valid=0)
//   sout_valid : high for every serial bit cycle
//   done       : one-cycle pulse after the last serial bit
// Modports: master = requester side, slave = readback engine.
// -----------------------------------------------------------------------------
interface register_readback_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] reg_in;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output start, reg_in,
    input  ready, sout, sout_valid, done
  );

  modport slave (
    input  start, reg_in,
    output ready, sout, sout_valid, done
  );
endinterface

// File: rtl/register_readback_shift_reg.sv
// -----------------------------------------------------------------------------
// readback_shift_reg
// WIDTH-bit parallel-load, shift-right register. Load has priority over shift;
// shifting fills the MSB with 0 so bit 0 always presents the next serial bit.
// Ports:
//   clk   : clock (rising edge)
//   reset : asynchronous, active-high; clears the register
//   load  : capture din
//   shift : shift right by one
//   din   : parallel load data
//   q     : register contents
// -----------------------------------------------------------------------------
module readback_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/register_readback.sv
// -----------------------------------------------------------------------------
// register_readback
// Serial readback engine: snapshots a WIDTH-bit register image when a request
// is accepted in IDLE and shifts it out LSB-first with a valid strobe, then
// pulses done for one cycle and returns to IDLE.
//
// Build option: define REGISTER_READBACK_PARITY_EN to append one even-parity
// bit (XOR of the snapshot) after the data bits through the PAR state.
// Without it, SHIFT goes straight to DONE and no parity logic exists.
//
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high; abandons any readback (no done)
//   bus   : register_readback_if.slave (start, reg_in in; ready, sout,
//           sout_valid, done out)
// All outputs decode from registered state only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module register_readback
  import register_readback_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  register_readback_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  rb_state_t        state;
  rb_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sr_q;
  logic             load;
  logic             shift;
  logic             last_bit;

  // A request is only seen in IDLE; start in any other state is dropped.
  assign load     = (state == IDLE) && bus.start;
  assign shift    = (state == SHIFT);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  readback_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (bus.reg_in),
    .q     (sr_q)
  );

  // Bit counter: cleared on capture, counts SHIFT cycles. It ends at WIDTH,
  // which CNT_W is sized to hold, so it never wraps inside a readback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (shift) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef REGISTER_READBACK_PARITY_EN
  logic par_q;

  // Parity is taken from the image at the capture edge, so later reg_in
  // changes cannot affect it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^bus.reg_in;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef REGISTER_READBACK_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef REGISTER_READBACK_PARITY_EN
      PAR:     state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ready      = (state == IDLE);
    bus.sout       = 1'b0;
    bus.sout_valid = 1'b0;
    bus.done       = 1'b0;
    case (state)
      SHIFT: begin
        bus.sout       = sr_q[0];
        bus.sout_valid = 1'b1;
      end
`ifdef REGISTER_READBACK_PARITY_EN
      PAR: begin
        bus.sout       = par_q;
        bus.sout_valid = 1'b1;
      end
`endif
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_register_readback.sv
// -----------------------------------------------------------------------------
// tb_register_readback
// Self-checking bench for register_readback (WIDTH=8 and WIDTH=1 instances).
// Follows REGISTER_READBACK_PARITY_EN to decide whether a parity bit follows
// the data bits.
// -----------------------------------------------------------------------------
module tb_register_readback;

`ifdef REGISTER_READBACK_PARITY_EN
  localparam int PAR_N = 1;
`else
  localparam int PAR_N = 0;
`endif
  localparam int NB8 = 8 + PAR_N;
  localparam int NB1 = 1 + PAR_N;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic q[$];

  register_readback_if #(.WIDTH(8)) bus8 ();
  register_readback_if #(.WIDTH(1)) bus1 ();

  register_readback #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  register_readback #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  // seq[7] is the first bit expected on sout, seq[0] the last data bit.
  task automatic push_seq(input logic [7:0] seq, input logic par);
    for (int i = 7; i >= 0; i--) q.push_back(seq[i]);
    if (PAR_N == 1) q.push_back(par);
  endtask

  // Scoreboard monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus8.sout_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_bit: actual=%b required=no valid bit at %0t",
                   bus8.sout, $time);
        end else begin
          chk("sb_bit", bus8.sout, q.pop_front());
        end
      end else begin
        chk("sout_zero_when_invalid", bus8.sout, 1'b0);
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
    logic       par;
    int         disturb;
  } vec_t;

  vec_t vecs[7];

  // One readback on the WIDTH=8 instance. If disturb is non-zero, reg_in is
  // forced to FF and start pulsed during that serial cycle.
  task automatic readback8(input logic [7:0] data, input logic [7:0] seq,
                           input logic par, input int disturb);
    @(negedge clk);
    chk("ready_before_start", bus8.ready, 1'b1);
    push_seq(seq, par);
    bus8.start  = 1'b1;
    bus8.reg_in = data;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int c = 1; c <= NB8; c++) begin
      if (c > 1) @(negedge clk);
      chk("valid_in_window", bus8.sout_valid, 1'b1);
      chk("ready_low_busy", bus8.ready, 1'b0);
      chk("done_low_busy", bus8.done, 1'b0);
      if (disturb != 0 && c == disturb) begin
        bus8.reg_in = 8'hFF;
        bus8.start  = 1'b1;
      end else if (disturb != 0 && c == disturb + 1) begin
        bus8.start = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_pulse", bus8.done, 1'b1);
    chk("valid_low_in_done", bus8.sout_valid, 1'b0);
    chk("ready_low_in_done", bus8.ready, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", bus8.done, 1'b0);
    chk("ready_after_done", bus8.ready, 1'b1);
    chk("valid_low_after_done", bus8.sout_valid, 1'b0);
    chk("scoreboard_drained", q.size() == 0, 1'b1);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, seq: 8'b1010_0101, par: 1'b0, disturb: 0};
    vecs[1] = '{data: 8'h07, seq: 8'b1110_0000, par: 1'b1, disturb: 0};
    vecs[2] = '{data: 8'h3C, seq: 8'b0011_1100, par: 1'b0, disturb: 0};
    vecs[3] = '{data: 8'h01, seq: 8'b1000_0000, par: 1'b1, disturb: 0};
    vecs[4] = '{data: 8'h80, seq: 8'b0000_0001, par: 1'b1, disturb: 0};
    vecs[5] = '{data: 8'hFF, seq: 8'b1111_1111, par: 1'b0, disturb: 0};
    vecs[6] = '{data: 8'hA5, seq: 8'b1010_0101, par: 1'b0, disturb: 3};

    reset       = 1'b1;
    bus8.start  = 1'b0;
    bus8.reg_in = '0;
    bus1.start  = 1'b0;
    bus1.reg_in = '0;

    #1;
    chk("rst_ready8", bus8.ready, 1'b1);
    chk("rst_valid8", bus8.sout_valid, 1'b0);
    chk("rst_sout8", bus8.sout, 1'b0);
    chk("rst_done8", bus8.done, 1'b0);
    chk("rst_ready1", bus1.ready, 1'b1);
    chk("rst_valid1", bus1.sout_valid, 1'b0);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      readback8(vecs[v].data, vecs[v].seq, vecs[v].par, vecs[v].disturb);
    end

    // Reset at data bit 4: outputs clear immediately, readback abandoned.
    @(negedge clk);
    push_seq(8'b1010_0101, 1'b0);
    bus8.start  = 1'b1;
    bus8.reg_in = 8'hA5;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("valid_at_bit4", bus8.sout_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", bus8.ready, 1'b1);
    chk("midrst_valid", bus8.sout_valid, 1'b0);
    chk("midrst_sout", bus8.sout, 1'b0);
    chk("midrst_done", bus8.done, 1'b0);
    q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", bus8.done, 1'b0);
      chk("ready_in_reset", bus8.ready, 1'b1);
    end
    // Release between edges so the very next rising edge accepts the request.
    @(posedge clk);
    #2 reset = 1'b0;
    readback8(8'h3C, 8'b0011_1100, 1'b0, 0);

    // WIDTH=1 with start held high: valid, done, ready, repeat.
    @(negedge clk);
    bus1.reg_in = 1'b1;
    bus1.start  = 1'b1;
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < NB1; c++) begin
        @(negedge clk);
        chk("w1_valid", bus1.sout_valid, 1'b1);
        chk("w1_sout", bus1.sout, 1'b1);
        chk("w1_busy_not_ready", bus1.ready, 1'b0);
      end
      @(negedge clk);
      chk("w1_done", bus1.done, 1'b1);
      chk("w1_done_valid_low", bus1.sout_valid, 1'b0);
      @(negedge clk);
      chk("w1_ready_gap", bus1.ready, 1'b1);
      chk("w1_gap_done_low", bus1.done, 1'b0);
      chk("w1_gap_valid_low", bus1.sout_valid, 1'b0);
    end
    bus1.start = 1'b0;
    @(negedge clk);
    chk("w1_stays_idle", bus1.sout_valid, 1'b0);
    chk("w8_stays_idle", bus8.sout_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
